montgomery_wrapper: RTL and testbench
=====================================

Name: montgomery_wrapper

Overview:
- Single-core RSA accelerator datapath behind a 32-bit command port and a 512-bit BRAM-style data port.
- Host loads operands, then starts either a single Montgomery multiplication or a full modular exponentiation X^E mod M, then writes the result back out.
- Sits between the processor-side command/BRAM interface and a bit-serial Montgomery multiplier.

Parameters:
- WORD_LEN, 512, operand/result width in bits; R = 2^WORD_LEN.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-high reset (asserted when 1, despite the name)
- bram_din1  in  WORD_LEN  operand data, core 1
- bram_din2  in  WORD_LEN  operand data, core 2 (unused, ignored)
- bram_din_valid  in  1  bram_din1 valid strobe
- bram_dout1  out  WORD_LEN  result data, core 1
- bram_dout2  out  WORD_LEN  tied to 0
- bram_dout1_valid  out  1  bram_dout1 holds a result
- bram_dout2_valid  out  1  tied to 0
- bram_dout_read  in  1  host consumed bram_dout1
- port1_din  in  32  command word (bits [3:0] decoded, rest ignored)
- port1_valid  in  1  command present
- port1_read  out  1  command accepted
- port2_valid  out  1  command complete
- port2_read  in  1  host acknowledges completion
- leds  out  4  current top-level state encoding

Behaviour:
- Reset (async, resetn=1): state IDLE; all operand/result registers 0; port1_read, port2_valid, bram_dout1_valid = 0; bram_dout1 = 0; leds = 0.
- Operand registers: X/A, E/B, M, R2M (R^2 mod M), RM (R mod M); result registers RES_MUL, RES_EXP.
- Commands:
  - 0..4 load X, E, M, R2M, RM respectively.
  - 5 start multiply.
  - 6 write RES_MUL.
  - 7 start exponentiation.
  - 8 write RES_EXP.
  - 9..15 are no-ops that still complete via port2.
- IDLE: when port1_valid=1, latch the command and enter ACK. port1_read=1 from the next cycle and held while port1_valid=1. When port1_valid=0, drop port1_read and dispatch.
- LOAD: wait for bram_din_valid=1, capture bram_din1 into the selected register that cycle, then go to DONE.
- MUL: RES_MUL = MontMul(A,B) = A*B*R^-1 mod M. Go to DONE when the multiplier finishes.
- EXP, left-to-right binary:
  - Xt = MontMul(X, R2M); Acc = RM.
  - For i = WORD_LEN-1 down to 0: Acc = MontMul(Acc, Acc); if E[i], Acc = MontMul(Acc, Xt).
  - RES_EXP = MontMul(Acc, 1).
  - Go to DONE.
- WRITE: drive bram_dout1 = selected result and bram_dout1_valid=1, held until bram_dout_read=1. Then clear valid and go to DONE. bram_dout1 keeps its value afterwards.
- DONE: port2_valid=1 until port2_read=1, then port2_valid=0 and return to IDLE. A port2_read held for several cycles is harmless.
- port1_valid during a busy state is ignored until IDLE.
- MontMul (radix-2, bit-serial):
  - C=0; for i=0..WORD_LEN-1: C = C + a_i*B; if C odd, C += M; C >>= 1.
  - Finally, if C ≥ M, C -= M.
  - Internal width WORD_LEN+2.
  - Precondition: M odd, B < M; A may be any value < 2^WORD_LEN. Result is < M.
  - Latency: WORD_LEN+2 cycles from start to done.
- Results are undefined for even M.
- Exponentiation latency is about (2*WORD_LEN+2)*(WORD_LEN+2) cycles worst case.
- Reset mid-operation aborts everything immediately; no partial result or handshake survives.

Decomposition:
- Package montgomery_pkg: WORD_LEN default, 4-bit command codes (CMD_LOAD_X..CMD_WRITE_EXP), top-level state enum.
- One sub-module montgomery_mult:
  - Inputs: clk, resetn, start, a, b, m.
  - Outputs: result, done (1-cycle pulse).
- Top holds the command FSM, registers and the exponentiation sequencer.

Test Plan:
- Exponentiation:
  - Load X=0xba613daa…8e33, E=0xa1, M=0x94107f76…aa65, R2M=0x50142167…4658, RM=0x6bef8089…559b via cmds 0..4.
  - Then cmd 7, then cmd 8 → bram_dout1 = 0x18f676d9…e135.
- Multiply:
  - Load A=0x93839e5e…31dd, B=0x8414…ec2a, M=0xdc40c654…6875.
  - Then cmd 5, then cmd 6 → bram_dout1 = 0x7bd8d21c…2a74.
- Exponent edge cases: same M/RM/R2M as the first scenario.
  - E=0 → RES_EXP = 1.
  - E=1 with X=0xba61…8e33 → RES_EXP = X − M.
- Handshake:
  - Hold port1_valid 5 cycles → port1_read stays high until valid drops.
  - port2_valid drops the cycle after port2_read.
  - bram_dout1_valid holds until bram_dout_read.
- Unknown command 0xF → port1_read, then port2_valid; all registers unchanged.
- Assert resetn during EXP:
  - All outputs return to 0 asynchronously.
  - A subsequent multiply from the second scenario still gives 0x7bd8d21c…2a74.

Source files
------------

// File: rtl/montgomery_pkg.sv
// Shared constants and state types for the Montgomery RSA wrapper.
// Command codes match bits [3:0] of the host command word.
package montgomery_pkg;

    localparam int WORD_LEN_DEF = 512;

    localparam logic [3:0] CMD_LOAD_X    = 4'd0;
    localparam logic [3:0] CMD_LOAD_E    = 4'd1;
    localparam logic [3:0] CMD_LOAD_M    = 4'd2;
    localparam logic [3:0] CMD_LOAD_R2M  = 4'd3;
    localparam logic [3:0] CMD_LOAD_RM   = 4'd4;
    localparam logic [3:0] CMD_MUL       = 4'd5;
    localparam logic [3:0] CMD_WRITE_MUL = 4'd6;
    localparam logic [3:0] CMD_EXP       = 4'd7;
    localparam logic [3:0] CMD_WRITE_EXP = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ACK   = 4'd1,
        S_LOAD  = 4'd2,
        S_MUL   = 4'd3,
        S_EXP   = 4'd4,
        S_WRITE = 4'd5,
        S_DONE  = 4'd6
    } state_t;

    typedef enum logic [1:0] {
        XP_PRE,
        XP_SQ,
        XP_MULX,
        XP_POST
    } xphase_t;

endpackage

// File: rtl/montgomery_mult.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WORD_LEN mod m.
// Operands are latched on start; done pulses WORD_LEN+2 cycles later.
module montgomery_mult
    import montgomery_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [WORD_LEN-1:0] a,
    input  logic [WORD_LEN-1:0] b,
    input  logic [WORD_LEN-1:0] m,
    output logic [WORD_LEN-1:0] result,
    output logic                done
);

    localparam int CW = $clog2(WORD_LEN + 1);

    logic [WORD_LEN-1:0] a_sh;
    logic [WORD_LEN+1:0] b_r;
    logic [WORD_LEN+1:0] m_r;
    logic [WORD_LEN+1:0] c;
    logic [WORD_LEN+1:0] sum;
    logic [WORD_LEN+1:0] sum_m;
    logic [WORD_LEN+1:0] diff;
    logic [CW-1:0]       cnt;
    logic                busy;

    always_comb begin
        sum   = c + (a_sh[0] ? b_r : '0);
        sum_m = sum[0] ? sum + m_r : sum;
        diff  = c - m_r;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            a_sh   <= '0;
            b_r    <= '0;
            m_r    <= '0;
            c      <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh <= a;
                b_r  <= {2'b00, b};
                m_r  <= {2'b00, m};
                c    <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (cnt != CW'(WORD_LEN)) begin
                    c    <= sum_m >> 1;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + CW'(1);
                end else begin
                    // c < 2m here, so one conditional subtract is enough
                    result <= (c >= m_r) ? diff[WORD_LEN-1:0]
                                         : c[WORD_LEN-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/montgomery_wrapper.sv
// Command FSM, operand/result registers and exponentiation sequencer
// wrapped around a single bit-serial Montgomery multiplier.
module montgomery_wrapper
    import montgomery_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WORD_LEN-1:0] bram_din1,
    input  logic [WORD_LEN-1:0] bram_din2,
    input  logic                bram_din_valid,
    output logic [WORD_LEN-1:0] bram_dout1,
    output logic [WORD_LEN-1:0] bram_dout2,
    output logic                bram_dout1_valid,
    output logic                bram_dout2_valid,
    input  logic                bram_dout_read,
    input  logic [31:0]         port1_din,
    input  logic                port1_valid,
    output logic                port1_read,
    output logic                port2_valid,
    input  logic                port2_read,
    output logic [3:0]          leds
);

    localparam int IW = $clog2(WORD_LEN);

    state_t  state;
    state_t  state_nx;
    xphase_t xphase;

    logic [3:0]          cmd;
    logic [WORD_LEN-1:0] reg_x;
    logic [WORD_LEN-1:0] reg_e;
    logic [WORD_LEN-1:0] reg_m;
    logic [WORD_LEN-1:0] reg_r2m;
    logic [WORD_LEN-1:0] reg_rm;
    logic [WORD_LEN-1:0] res_mul;
    logic [WORD_LEN-1:0] res_exp;
    logic [WORD_LEN-1:0] acc;
    logic [WORD_LEN-1:0] xt;
    logic [IW-1:0]       idx;
    logic                go;

    logic [WORD_LEN-1:0] mm_a;
    logic [WORD_LEN-1:0] mm_b;
    logic [WORD_LEN-1:0] mm_res;
    logic                mm_done;
    logic                unused_in;

    assign unused_in        = ^{bram_din2, port1_din[31:4]};
    assign port1_read       = (state == S_ACK) && port1_valid;
    assign port2_valid      = (state == S_DONE);
    assign bram_dout1_valid = (state == S_WRITE);
    assign bram_dout2       = '0;
    assign bram_dout2_valid = 1'b0;
    assign leds             = state;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (port1_valid) state_nx = S_ACK;
            S_ACK: begin
                if (!port1_valid) begin
                    unique case (1'b1)
                        (cmd <= CMD_LOAD_RM):    state_nx = S_LOAD;
                        (cmd == CMD_MUL):        state_nx = S_MUL;
                        (cmd == CMD_EXP):        state_nx = S_EXP;
                        (cmd == CMD_WRITE_MUL),
                        (cmd == CMD_WRITE_EXP):  state_nx = S_WRITE;
                        default:                 state_nx = S_DONE;
                    endcase
                end
            end
            S_LOAD:  if (bram_din_valid) state_nx = S_DONE;
            S_MUL:   if (mm_done) state_nx = S_DONE;
            S_EXP:   if (mm_done && xphase == XP_POST) state_nx = S_DONE;
            S_WRITE: if (bram_dout_read) state_nx = S_DONE;
            S_DONE:  if (port2_read) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Multiplier operand select; plain multiply uses the X/A and E/B slots
    always_comb begin
        mm_a = reg_x;
        mm_b = reg_e;
        if (state == S_EXP) begin
            unique case (xphase)
                XP_PRE:  mm_b = reg_r2m;
                XP_SQ:   begin mm_a = acc; mm_b = acc; end
                XP_MULX: begin mm_a = acc; mm_b = xt; end
                XP_POST: begin mm_a = acc; mm_b = WORD_LEN'(1); end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state      <= S_IDLE;
            xphase     <= XP_PRE;
            cmd        <= '0;
            reg_x      <= '0;
            reg_e      <= '0;
            reg_m      <= '0;
            reg_r2m    <= '0;
            reg_rm     <= '0;
            res_mul    <= '0;
            res_exp    <= '0;
            acc        <= '0;
            xt         <= '0;
            idx        <= '0;
            go         <= 1'b0;
            bram_dout1 <= '0;
        end else begin
            state <= state_nx;
            go    <= 1'b0;
            if (state == S_IDLE && port1_valid)
                cmd <= port1_din[3:0];
            if (state == S_ACK && state_nx != S_ACK) begin
                if (state_nx == S_MUL)
                    go <= 1'b1;
                if (state_nx == S_EXP) begin
                    go     <= 1'b1;
                    xphase <= XP_PRE;
                end
                if (state_nx == S_WRITE)
                    bram_dout1 <= (cmd == CMD_WRITE_EXP) ? res_exp : res_mul;
            end
            if (state == S_LOAD && bram_din_valid) begin
                case (cmd)
                    CMD_LOAD_X:   reg_x   <= bram_din1;
                    CMD_LOAD_E:   reg_e   <= bram_din1;
                    CMD_LOAD_M:   reg_m   <= bram_din1;
                    CMD_LOAD_R2M: reg_r2m <= bram_din1;
                    CMD_LOAD_RM:  reg_rm  <= bram_din1;
                    default: ;
                endcase
            end
            if (state == S_MUL && mm_done)
                res_mul <= mm_res;
            // Left-to-right square-and-multiply over every exponent bit
            if (state == S_EXP && mm_done) begin
                unique case (xphase)
                    XP_PRE: begin
                        xt     <= mm_res;
                        acc    <= reg_rm;
                        idx    <= IW'(WORD_LEN - 1);
                        xphase <= XP_SQ;
                        go     <= 1'b1;
                    end
                    XP_SQ: begin
                        acc <= mm_res;
                        go  <= 1'b1;
                        if (reg_e[idx])
                            xphase <= XP_MULX;
                        else if (idx == '0)
                            xphase <= XP_POST;
                        else
                            idx <= idx - IW'(1);
                    end
                    XP_MULX: begin
                        acc <= mm_res;
                        go  <= 1'b1;
                        if (idx == '0) begin
                            xphase <= XP_POST;
                        end else begin
                            idx    <= idx - IW'(1);
                            xphase <= XP_SQ;
                        end
                    end
                    XP_POST: res_exp <= mm_res;
                    default: ;
                endcase
            end
        end
    end

    montgomery_mult #(
        .WORD_LEN(WORD_LEN)
    ) u_mult (
        .clk    (clk),
        .resetn (resetn),
        .start  (go),
        .a      (mm_a),
        .b      (mm_b),
        .m      (reg_m),
        .result (mm_res),
        .done   (mm_done)
    );

endmodule

// File: tb/tb_montgomery_wrapper.sv
// Scoreboard bench for montgomery_wrapper at a reduced word length,
// checked against a plain-arithmetic modular reference model.
module tb_montgomery_wrapper;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [W-1:0]  bram_din1 = '0;
    logic [W-1:0]  bram_din2 = '0;
    logic          bram_din_valid = 1'b0;
    logic [W-1:0]  bram_dout1;
    logic [W-1:0]  bram_dout2;
    logic          bram_dout1_valid;
    logic          bram_dout2_valid;
    logic          bram_dout_read = 1'b0;
    logic [31:0]   port1_din = '0;
    logic          port1_valid = 1'b0;
    logic          port1_read;
    logic          port2_valid;
    logic          port2_read = 1'b0;
    logic [3:0]    leds;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] shadow[5];
    logic         mon_prev = 1'b0;

    always #5 clk = ~clk;

    montgomery_wrapper #(.WORD_LEN(W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bram_din1        (bram_din1),
        .bram_din2        (bram_din2),
        .bram_din_valid   (bram_din_valid),
        .bram_dout1       (bram_dout1),
        .bram_dout2       (bram_dout2),
        .bram_dout1_valid (bram_dout1_valid),
        .bram_dout2_valid (bram_dout2_valid),
        .bram_dout_read   (bram_dout_read),
        .port1_din        (port1_din),
        .port1_valid      (port1_valid),
        .port1_read       (port1_read),
        .port2_valid      (port2_valid),
        .port2_read       (port2_read),
        .leds             (leds)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // a*b*R^-1 mod m, using 2^-1 = (m+1)/2 for odd m
    function automatic logic [W-1:0] ref_mont(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [W-1:0] m);
        longint unsigned p, half, mm, a64, b64;
        mm   = 64'(m);
        a64  = 64'(a);
        b64  = 64'(b);
        p    = (a64 * b64) % mm;
        half = (mm + 1) / 2;
        for (int i = 0; i < W; i++)
            p = (p * half) % mm;
        return W'(p);
    endfunction

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] x,
                                                input logic [W-1:0] e,
                                                input logic [W-1:0] m);
        longint unsigned r, base, mm;
        mm   = 64'(m);
        r    = 1 % mm;
        base = 64'(x) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i])
                r = (r * base) % mm;
            base = (base * base) % mm;
        end
        return W'(r);
    endfunction

    function automatic logic [W-1:0] ref_rm(input logic [W-1:0] m);
        longint unsigned one_r;
        one_r = 64'h1_0000_0000;
        return W'(one_r % 64'(m));
    endfunction

    function automatic logic [W-1:0] ref_r2m(input logic [W-1:0] m);
        longint unsigned rm;
        rm = 64'(ref_rm(m));
        return W'((rm * rm) % 64'(m));
    endfunction

    // Monitor: compare each new result presented on bram_dout1
    always @(negedge clk) begin
        if (bram_dout1_valid && !mon_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h, expected none",
                         bram_dout1);
            end else begin
                chk("write_data", bram_dout1, exp_q.pop_front());
            end
        end
        mon_prev <= bram_dout1_valid;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [3:0] c, input int hold);
        @(posedge clk);
        #1;
        port1_din   = {28'($urandom()), c};
        port1_valid = 1'b1;
        for (int n = 0; n < 20 && !port1_read; n++)
            @(negedge clk);
        chk("port1_read_rise", 32'(port1_read), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("port1_read_hold", 32'(port1_read), 32'd1);
        end
        @(posedge clk);
        #1 port1_valid = 1'b0;
        @(negedge clk);
        chk("port1_read_drop", 32'(port1_read), 32'd0);
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int n = 0; n < budget && !port2_valid; n++)
            @(negedge clk);
        chk({name, "_done"}, 32'(port2_valid), 32'd1);
        if (port2_valid) begin
            @(posedge clk);
            #1 port2_read = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("port2_drop", 32'(port2_valid), 32'd0);
            @(posedge clk);
            #1 port2_read = 1'b0;
        end
    endtask

    task automatic load(input logic [3:0] c, input logic [W-1:0] v);
        send_cmd(c, 0);
        @(posedge clk);
        #1;
        bram_din1      = v;
        bram_din_valid = 1'b1;
        @(posedge clk);
        #1;
        bram_din_valid = 1'b0;
        bram_din1      = $urandom();
        shadow[c]      = v;
        wait_done(20, "load");
    endtask

    task automatic run(input logic [3:0] c, input string name);
        send_cmd(c, 0);
        wait_done(12000, name);
    endtask

    task automatic write_res(input logic [3:0] c, input logic [W-1:0] expv);
        exp_q.push_back(expv);
        send_cmd(c, 0);
        for (int n = 0; n < 20 && !bram_dout1_valid; n++)
            @(negedge clk);
        chk("dout_valid_rise", 32'(bram_dout1_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("dout_valid_hold", 32'(bram_dout1_valid), 32'd1);
        end
        @(posedge clk);
        #1 bram_dout_read = 1'b1;
        @(posedge clk);
        #1 bram_dout_read = 1'b0;
        @(negedge clk);
        chk("dout_valid_drop", 32'(bram_dout1_valid), 32'd0);
        chk("dout_keep", bram_dout1, expv);
        wait_done(20, "write");
    endtask

    task automatic load_exp(input logic [W-1:0] x, input logic [W-1:0] e,
                            input logic [W-1:0] m);
        load(4'd0, x);
        load(4'd1, e);
        load(4'd2, m);
        load(4'd3, ref_r2m(m));
        load(4'd4, ref_rm(m));
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_p1read"}, 32'(port1_read), 32'd0);
        chk({name, "_p2valid"}, 32'(port2_valid), 32'd0);
        chk({name, "_dvalid"}, 32'(bram_dout1_valid), 32'd0);
        chk({name, "_dout1"}, bram_dout1, 32'd0);
        chk({name, "_leds"}, 32'(leds), 32'd0);
        chk({name, "_dout2"}, bram_dout2, 32'd0);
        chk({name, "_d2valid"}, 32'(bram_dout2_valid), 32'd0);
    endtask

    logic [W-1:0] m1, x1, e1, m2, a2, b2, mul2, xe;
    logic [W-1:0] last_mul, last_exp, mm, aa, bb;

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 resetn = 1'b0;

        m1 = $urandom() | 32'h8000_0001;
        x1 = $urandom();
        e1 = $urandom() | 32'h8000_0000;
        load_exp(x1, e1, m1);
        run(4'd7, "exp");
        last_exp = ref_modexp(x1, e1, m1);
        write_res(4'd8, last_exp);

        m2 = $urandom() | 32'h8000_0001;
        a2 = $urandom();
        b2 = $urandom() % m2;
        mul2 = ref_mont(a2, b2, m2);
        load(4'd0, a2);
        load(4'd1, b2);
        load(4'd2, m2);
        run(4'd5, "mul");
        last_mul = mul2;
        write_res(4'd6, last_mul);

        load_exp(x1, 32'd0, m1);
        run(4'd7, "exp_e0");
        last_exp = 32'd1;
        write_res(4'd8, last_exp);

        xe = m1 + ($urandom() % (~m1 + 32'd1));
        load(4'd0, xe);
        load(4'd1, 32'd1);
        run(4'd7, "exp_e1");
        last_exp = xe - m1;
        write_res(4'd8, last_exp);

        for (int k = 0; k < 3; k++) begin
            mm = $urandom() | 32'h0000_0001;
            if (mm < 32'd3) mm = 32'd3;
            aa = $urandom();
            bb = $urandom() % mm;
            load(4'd0, aa);
            load(4'd1, bb);
            load(4'd2, mm);
            run(4'd5, "mul_rand");
            last_mul = ref_mont(aa, bb, mm);
            write_res(4'd6, last_mul);

            mm = $urandom() | 32'h4000_0001;
            aa = $urandom();
            bb = $urandom();
            load_exp(aa, bb, mm);
            run(4'd7, "exp_rand");
            last_exp = ref_modexp(aa, bb, mm);
            write_res(4'd8, last_exp);
        end

        send_cmd(4'hF, 5);
        wait_done(20, "nop");
        write_res(4'd6, last_mul);
        write_res(4'd8, last_exp);
        run(4'd7, "exp_after_nop");
        write_res(4'd8, ref_modexp(shadow[0], shadow[1], shadow[2]));

        load_exp(x1, e1, m1);
        send_cmd(4'd7, 0);
        repeat (100) @(posedge clk);
        #2 resetn = 1'b1;
        #1 check_idle_outputs("midreset");
        @(posedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_p2valid_after", 32'(port2_valid), 32'd0);

        load(4'd0, a2);
        load(4'd1, b2);
        load(4'd2, m2);
        run(4'd5, "mul_after_reset");
        write_res(4'd6, mul2);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
